lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC-3 core's memory interface. It answers the core's MAR/MDR accesses: an asynchronous read path drives `data_out` from `addr`, and writes strobed by `memWE` go through a 2-entry posted-write buffer that commits to the word array after a programmable number of wait states. Reads forward pending buffered data. It also provides a testbench backdoor preload port and sticky status outputs, and sits opposite the core on the same `lc3_if` signal set.

## Interface
- `AW`, default 10: array index width; the array holds 2^AW 16-bit words.
- `WAIT`, default 0: wait cycles before each buffered write commits (0–15).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  16  word address (MAR); only `addr[AW-1:0]` is used.
- `data_in`  in  16  write data from the core (MDR).
- `memWE`  in  1  write strobe; each high cycle is one write request.
- `ldMAR`  in  1  address-load strobe; counted only.
- `data_out`  out  16  read data for `addr`.
- `mem_rdy`  out  1  high when the write buffer is empty.
- `wr_ovf`  out  1  sticky: a write was dropped because the buffer was full.
- `acc_cnt`  out  16  number of cycles with `ldMAR` high; saturates at 16'hFFFF.
- `ld_en`  in  1  backdoor write enable.
- `ld_addr`  in  AW  backdoor word index.
- `ld_data`  in  16  backdoor write data.

## Operation
- **Address aliasing:** index = `addr[AW-1:0]`. Upper bits are ignored, so addresses alias modulo 2^AW.
- **Read path:** combinational `data_out` for the current `addr`, in priority order:
  - the data of the newest buffered entry whose index matches;
  - otherwise the array word.
- **Write push:** on an edge with `memWE`=1, {index, `data_in`} is pushed to the tail of the FIFO (2 entries).
- **Push when full:** the push is accepted if fewer than 2 entries are held, or if a pop occurs on the same edge. Otherwise the write is dropped and `wr_ovf` is set to 1. `wr_ovf` stays set until reset.
- **Drain FSM:**
  - EMPTY: no entries. Moves to DRAIN when a push is accepted, with `wcnt` = WAIT.
  - DRAIN: if `wcnt`=0 on an edge, the head commits to the array and is popped.
    - If an entry remains (or one is pushed on the same edge), stay in DRAIN and reload `wcnt` = WAIT.
    - Otherwise go to EMPTY.
  - DRAIN with `wcnt`≠0: decrement `wcnt`.
- **Backdoor:** on an edge with `ld_en`=1, the array word at `ld_addr` is written directly. It does not touch the FIFO.
- **Backdoor vs commit:** if a backdoor write and a commit hit the same word on the same edge, the backdoor value is stored. The commit still pops.
- **Access counter:** `acc_cnt` increments on each edge with `ldMAR`=1 and saturates at 16'hFFFF.
- **Reset:** clears the FIFO (pending writes are discarded), FSM → EMPTY, `wcnt`=0, `wr_ovf`=0, `acc_cnt`=0. Array contents are not reset; they are X until written.
- **Reset values of outputs:** `mem_rdy`=1, `wr_ovf`=0, `acc_cnt`=0. `data_out` is the array word at `addr`, because the FIFO is empty.

## Timing
- **Read latency:** 0 cycles (combinational from `addr`). A value loaded into MAR on edge t is valid on `data_out` during the cycle after t, which is the cycle in which the core loads MDR.
- **Write commit:** a write pushed into an empty buffer at edge t commits at edge t+1+WAIT.
- **Back-to-back commits:** successive entries commit WAIT+1 edges apart.
- **`mem_rdy`:** falls the cycle after an accepted push into an empty buffer. It rises the cycle after the last pop.
- **Forwarding window:** forwarding covers the whole span from the cycle after the push until the commit edge. Read-after-write therefore returns the new data with no stall.
- **Async reset:** asserting `rst` mid-drain empties the buffer immediately, without waiting for a clock. Words already committed are retained.
- **Push/pop on one edge:** with 1 entry held, the head pops and the new entry becomes the sole entry. With 2 entries held, the push is accepted because a slot frees on that edge.

## Test plan
- **Reset values:** assert `rst` → `mem_rdy`=1, `wr_ovf`=0, `acc_cnt`=0. Backdoor-load word 5 = 16'h1234, set `addr`=16'h0005 → `data_out`=16'h1234 in the same cycle.
- **Forwarding and commit, WAIT=2:**
  - `memWE` at edge t with `addr`=16'h0010, `data_in`=16'hBEEF → `mem_rdy`=0 from t+1.
  - `data_out`=16'hBEEF while `addr`=16'h0010 (forwarded).
  - Commit at edge t+3; `mem_rdy`=1 after t+3.
- **Overflow, WAIT=3:** writes on 3 consecutive edges to indices 1, 2, 3 → index 3 dropped, `wr_ovf`=1. Index 1 commits at t+4, index 2 at t+8. Reading index 3 returns its old value.
- **Newest entry wins, WAIT=4:** two writes to `addr`=16'h0400 (aliases index 0 with AW=10) with data 16'hAAAA then 16'h5555 → `data_out`=16'h5555 throughout. After both commits, array index 0 = 16'h5555.
- **Reset mid-drain:** pulse `rst` mid-drain with 1 entry pending → `mem_rdy`=1 immediately and the pending write is lost. A word committed earlier still reads back its value.
- **Counter saturation and backdoor priority:** hold `ldMAR` for 65540 cycles → `acc_cnt`=16'hFFFF. Backdoor write and commit to the same word on one edge → the backdoor data is stored.

Source files
------------

// File: rtl/lc3_mem_responder_if.sv
// lc3_mem_responder_if: signal bundle between the LC-3 core and its memory.
//   master (core):  drives addr (MAR), data_in (MDR), memWE, ldMAR;
//                   sees data_out, mem_rdy, wr_ovf, acc_cnt.
//   slave (memory): the reverse.
interface lc3_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        memWE;
    logic        ldMAR;
    logic [15:0] data_out;
    logic        mem_rdy;
    logic        wr_ovf;
    logic [15:0] acc_cnt;

    modport master (
        output addr, data_in, memWE, ldMAR,
        input  data_out, mem_rdy, wr_ovf, acc_cnt
    );

    modport slave (
        input  addr, data_in, memWE, ldMAR,
        output data_out, mem_rdy, wr_ovf, acc_cnt
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: memory-side responder for the LC-3 core.
//   Reads are combinational from bus.addr, forwarding the newest pending buffered write.
//   Writes (bus.memWE) enter a 2-entry posted-write FIFO; each entry commits to the
//   word array after WAIT wait cycles. A full FIFO drops the write and sets bus.wr_ovf.
// Ports:
//   clk, rst             clock, async active-high reset
//   bus (slave)          addr/data_in/memWE/ldMAR in; data_out/mem_rdy/wr_ovf/acc_cnt out
//   ld_en/ld_addr/ld_data backdoor array write, bypasses the FIFO, wins over a commit
module lc3_mem_responder #(
    parameter int unsigned AW   = 10,
    parameter int unsigned WAIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    lc3_mem_responder_if.slave  bus,
    input  logic                ld_en,
    input  logic [AW-1:0]       ld_addr,
    input  logic [15:0]         ld_data
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [0:0] {StEmpty, StDrain} state_e;

    state_e               state_q, state_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0][AW-1:0]   idx_q, idx_d;   // slot 0 is the head (oldest)
    logic [1:0][15:0]     dat_q, dat_d;
    logic                 wr_ovf_q, wr_ovf_d;
    logic [15:0]          acc_q, acc_d;

    logic [15:0]          mem [DEPTH];

    logic [AW-1:0]        idx_in;
    logic                 pop;
    logic                 push_ok;
    logic [15:0]          rd_data;

    // Upper address bits alias away by design.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[15:AW];

    assign idx_in  = bus.addr[AW-1:0];
    assign pop     = (state_q == StDrain) && (wcnt_q == 4'd0);
    // A full FIFO still accepts a push when the head pops on the same edge.
    assign push_ok = bus.memWE && ((cnt_q != 2'd2) || pop);

    // FIFO next state: pop shifts slot 1 into the head, then push lands after what remains.
    always_comb begin
        idx_d = idx_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (pop) begin
            idx_d[0] = idx_q[1];
            dat_d[0] = dat_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (push_ok) begin
            idx_d[cnt_d[0]] = idx_in;
            dat_d[cnt_d[0]] = bus.data_in;
            cnt_d           = cnt_d + 2'd1;
        end
    end

    // Drain FSM: count down WAIT cycles per entry, commit the head when the count is zero.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StEmpty: begin
                if (push_ok) begin
                    state_d = StDrain;
                    wcnt_d  = WAIT_CNT;
                end
            end
            StDrain: begin
                if (pop) begin
                    if ((cnt_q == 2'd2) || push_ok) begin
                        wcnt_d = WAIT_CNT;
                    end else begin
                        state_d = StEmpty;
                        wcnt_d  = 4'd0;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StEmpty;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    always_comb begin
        wr_ovf_d = wr_ovf_q | (bus.memWE & ~push_ok);
        acc_d    = acc_q;
        if (bus.ldMAR && (acc_q != 16'hFFFF)) begin
            acc_d = acc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            wcnt_q   <= 4'd0;
            cnt_q    <= 2'd0;
            idx_q    <= '0;
            dat_q    <= '0;
            wr_ovf_q <= 1'b0;
            acc_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dat_q    <= dat_d;
            wr_ovf_q <= wr_ovf_d;
            acc_q    <= acc_d;
        end
    end

    // Word array is not reset. The backdoor write is last so it wins on a same-word clash.
    always_ff @(posedge clk) begin
        if (pop) begin
            mem[idx_q[0]] <= dat_q[0];
        end
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Read path: newest matching FIFO entry, else the array.
    always_comb begin
        rd_data = mem[idx_in];
        if ((cnt_q != 2'd0) && (idx_q[0] == idx_in)) begin
            rd_data = dat_q[0];
        end
        if ((cnt_q == 2'd2) && (idx_q[1] == idx_in)) begin
            rd_data = dat_q[1];
        end
    end

    assign bus.data_out = rd_data;
    assign bus.mem_rdy  = (cnt_q == 2'd0);
    assign bus.wr_ovf   = wr_ovf_q;
    assign bus.acc_cnt  = acc_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    lc3_mem_responder_if bus2 ();
    lc3_mem_responder_if bus3 ();
    lc3_mem_responder_if bus4 ();

    logic        ld_en2, ld_en3, ld_en4;
    logic [9:0]  ld_addr2, ld_addr3, ld_addr4;
    logic [15:0] ld_data2, ld_data3, ld_data4;

    lc3_mem_responder #(.AW(10), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .ld_en(ld_en2), .ld_addr(ld_addr2), .ld_data(ld_data2)
    );
    lc3_mem_responder #(.AW(10), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .ld_en(ld_en3), .ld_addr(ld_addr3), .ld_data(ld_data3)
    );
    lc3_mem_responder #(.AW(10), .WAIT(4)) u_w4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .ld_en(ld_en4), .ld_addr(ld_addr4), .ld_data(ld_data4)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus2.addr = 16'h0; bus2.data_in = 16'h0; bus2.memWE = 1'b0; bus2.ldMAR = 1'b0;
        bus3.addr = 16'h0; bus3.data_in = 16'h0; bus3.memWE = 1'b0; bus3.ldMAR = 1'b0;
        bus4.addr = 16'h0; bus4.data_in = 16'h0; bus4.memWE = 1'b0; bus4.ldMAR = 1'b0;
        ld_en2 = 1'b0; ld_addr2 = 10'h0; ld_data2 = 16'h0;
        ld_en3 = 1'b0; ld_addr3 = 10'h0; ld_data3 = 16'h0;
        ld_en4 = 1'b0; ld_addr4 = 10'h0; ld_data4 = 16'h0;

        // Reset values
        tick();
        tick();
        check("rst mem_rdy", 16'(bus2.mem_rdy), 16'h1);
        check("rst wr_ovf", 16'(bus2.wr_ovf), 16'h0);
        check("rst acc_cnt", bus2.acc_cnt, 16'h0000);
        check("rst w3 wr_ovf", 16'(bus3.wr_ovf), 16'h0);
        rst = 1'b0;
        tick();

        // Backdoor load, combinational read
        ld_en2 = 1'b1; ld_addr2 = 10'h005; ld_data2 = 16'h1234;
        tick();
        ld_en2 = 1'b0;
        bus2.addr = 16'h0005;
        #1;
        check("backdoor read", bus2.data_out, 16'h1234);

        // WAIT=2: push at t, forwarded, commit at t+3
        bus2.addr = 16'h0010; bus2.data_in = 16'hBEEF; bus2.memWE = 1'b1;
        tick();                                     // edge t
        bus2.memWE = 1'b0;
        check("w2 rdy t+0", 16'(bus2.mem_rdy), 16'h0);
        check("w2 fwd t+0", bus2.data_out, 16'hBEEF);
        tick();                                     // t+1
        check("w2 fwd t+1", bus2.data_out, 16'hBEEF);
        tick();                                     // t+2
        check("w2 rdy t+2", 16'(bus2.mem_rdy), 16'h0);
        check("w2 fwd t+2", bus2.data_out, 16'hBEEF);
        tick();                                     // t+3 commit
        check("w2 rdy t+3", 16'(bus2.mem_rdy), 16'h1);
        check("w2 array", bus2.data_out, 16'hBEEF);

        // WAIT=3 overflow: preload index 3, then three back-to-back writes
        ld_en3 = 1'b1; ld_addr3 = 10'h003; ld_data3 = 16'h3333;
        tick();
        ld_en3 = 1'b0;
        bus3.memWE = 1'b1;
        bus3.addr = 16'h0001; bus3.data_in = 16'hA001;
        tick();                                     // edge t
        bus3.addr = 16'h0002; bus3.data_in = 16'hA002;
        tick();                                     // t+1
        check("w3 no ovf yet", 16'(bus3.wr_ovf), 16'h0);
        bus3.addr = 16'h0003; bus3.data_in = 16'hA003;
        tick();                                     // t+2 dropped
        bus3.memWE = 1'b0;
        check("w3 wr_ovf", 16'(bus3.wr_ovf), 16'h1);
        check("w3 idx3 old", bus3.data_out, 16'h3333);
        repeat (5) tick();                          // t+7
        check("w3 rdy t+7", 16'(bus3.mem_rdy), 16'h0);
        tick();                                     // t+8
        check("w3 rdy t+8", 16'(bus3.mem_rdy), 16'h1);
        check("w3 ovf sticky", 16'(bus3.wr_ovf), 16'h1);
        bus3.addr = 16'h0001;
        #1;
        check("w3 idx1", bus3.data_out, 16'hA001);
        bus3.addr = 16'h0002;
        #1;
        check("w3 idx2", bus3.data_out, 16'hA002);

        // WAIT=4: two writes to an aliased address, newest wins
        ld_en4 = 1'b1; ld_addr4 = 10'h020; ld_data4 = 16'h1111;
        tick();
        ld_en4 = 1'b0;
        bus4.memWE = 1'b1;
        bus4.addr = 16'h0400; bus4.data_in = 16'hAAAA;
        tick();                                     // edge t
        check("w4 first", bus4.data_out, 16'hAAAA);
        bus4.data_in = 16'h5555;
        tick();                                     // t+1
        bus4.memWE = 1'b0;
        check("w4 newest t+1", bus4.data_out, 16'h5555);
        for (int i = 2; i <= 9; i++) begin
            tick();
            check("w4 newest", bus4.data_out, 16'h5555);
        end
        check("w4 rdy t+9", 16'(bus4.mem_rdy), 16'h0);
        tick();                                     // t+10
        check("w4 rdy t+10", 16'(bus4.mem_rdy), 16'h1);
        check("w4 array 400", bus4.data_out, 16'h5555);
        bus4.addr = 16'h0000;
        #1;
        check("w4 array 000", bus4.data_out, 16'h5555);

        // Async reset mid-drain
        bus4.addr = 16'h0020; bus4.data_in = 16'h7777; bus4.memWE = 1'b1;
        tick();
        bus4.memWE = 1'b0;
        check("w4 pending fwd", bus4.data_out, 16'h7777);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("async rst rdy", 16'(bus4.mem_rdy), 16'h1);
        check("async rst lost", bus4.data_out, 16'h1111);
        check("rst clears ovf", 16'(bus3.wr_ovf), 16'h0);
        bus4.addr = 16'h0000;
        #1;
        check("rst keeps word", bus4.data_out, 16'h5555);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        bus4.addr = 16'h0020;
        #1;
        check("lost stays lost", bus4.data_out, 16'h1111);

        // Backdoor beats a commit to the same word on the same edge
        bus2.addr = 16'h0030; bus2.data_in = 16'hC0DE; bus2.memWE = 1'b1;
        tick();                                     // edge t
        bus2.memWE = 1'b0;
        tick();
        tick();
        ld_en2 = 1'b1; ld_addr2 = 10'h030; ld_data2 = 16'hFACE;
        tick();                                     // t+3 commit + backdoor
        ld_en2 = 1'b0;
        check("bd prio rdy", 16'(bus2.mem_rdy), 16'h1);
        check("bd prio data", bus2.data_out, 16'hFACE);

        // Push accepted into a full FIFO on the pop edge
        bus2.memWE = 1'b1;
        bus2.addr = 16'h0040; bus2.data_in = 16'hD001;
        tick();                                     // edge t
        bus2.addr = 16'h0041; bus2.data_in = 16'hD002;
        tick();                                     // t+1
        bus2.memWE = 1'b0;
        tick();                                     // t+2
        bus2.memWE = 1'b1;
        bus2.addr = 16'h0042; bus2.data_in = 16'hD003;
        tick();                                     // t+3 pop + push
        bus2.memWE = 1'b0;
        check("pp no ovf", 16'(bus2.wr_ovf), 16'h0);
        check("pp fwd", bus2.data_out, 16'hD003);
        repeat (5) tick();                          // t+8
        check("pp rdy t+8", 16'(bus2.mem_rdy), 16'h0);
        tick();                                     // t+9
        check("pp rdy t+9", 16'(bus2.mem_rdy), 16'h1);
        bus2.addr = 16'h0041;
        #1;
        check("pp idx41", bus2.data_out, 16'hD002);
        bus2.addr = 16'h0042;
        #1;
        check("pp idx42", bus2.data_out, 16'hD003);

        // Access counter and saturation
        check("acc idle", bus2.acc_cnt, 16'h0000);
        bus2.ldMAR = 1'b1;
        repeat (3) tick();
        check("acc 3", bus2.acc_cnt, 16'h0003);
        repeat (65532) tick();
        check("acc max", bus2.acc_cnt, 16'hFFFF);
        repeat (5) tick();
        check("acc sat", bus2.acc_cnt, 16'hFFFF);
        bus2.ldMAR = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
